// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its bulk-clear engine.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 32;

   localparam logic [DEF_DATA_W-1:0] ZeroWord = '0;
   localparam logic WriteEnable = 1'b1;
   localparam logic ReadEnable  = 1'b1;
   localparam logic RstEnable   = 1'b1;

   typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential bulk-clear engine: walks every entry once, emitting one clear write per cycle.
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   clr_state_t        r_state;
   clr_state_t        w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_state <= CLR_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      clr_we      = 1'b0;
      case (r_state)
         CLR_IDLE: begin
            if (clr_req) begin
               w_state_nxt = CLR_RUN;
               w_cnt_nxt   = '0;
            end
         end
         CLR_RUN: begin
            // clr_req is deliberately not looked at here: a running clear never restarts
            clr_we = 1'b1;
            if (r_cnt == ADDR_W'(DEPTH - 1)) begin
               w_state_nxt = CLR_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = CLR_IDLE;
      endcase
   end

   assign clr_addr = r_cnt;
   assign clr_busy = (r_state == CLR_RUN) && (rst != RstEnable);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: clocked writes, combinational reads with optional bypass,
// an unbypassed debug read port, optional hardwired-zero R0 and a bulk-clear engine.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int NR      = 2,
   parameter int NW      = 2,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NW-1:0]                write,
   input  logic [NW-1:0][ADDR_W-1:0]    waddr,
   input  logic [NW-1:0][DATA_W-1:0]    din,
   input  logic [NR-1:0]                read,
   input  logic [NR-1:0][ADDR_W-1:0]    raddr,
   output logic [NR-1:0][DATA_W-1:0]    dout,
   input  logic                         swread,
   input  logic [ADDR_W-1:0]            swaddr,
   output logic [DATA_W-1:0]            swdout,
   input  logic                         clr_req,
   output logic                         clr_busy
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;

   // An address is usable when it is in range and is not the hardwired-zero R0
   function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
      return (int'(a) < DEPTH) && !((ZERO_R0 != 0) && (a == '0));
   endfunction

   regfile_clr_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr_fsm (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_we   (w_clr_we),
      .clr_addr (w_clr_addr)
   );

   // Later assignments win: higher port index beats lower, and the clear beats every user write
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         for (int k = 0; k < NW; k++) begin
            if (write[k] == WriteEnable && addr_legal(waddr[k])) r_mem[waddr[k]] <= din[k];
         end
         if (w_clr_we) r_mem[w_clr_addr] <= DATA_W'(ZeroWord);
      end
   end

   always_comb begin
      for (int j = 0; j < NR; j++) begin
         dout[j] = '0;
         if (rst != RstEnable && read[j] == ReadEnable && addr_legal(raddr[j])) begin
            dout[j] = r_mem[raddr[j]];
            if (BYPASS != 0) begin
               for (int k = 0; k < NW; k++) begin
                  if (write[k] == WriteEnable && waddr[k] == raddr[j]) dout[j] = din[k];
               end
            end
         end
      end
   end

   always_comb begin
      swdout = '0;
      if (rst != RstEnable && swread == ReadEnable && addr_legal(swaddr)) swdout = r_mem[swaddr];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: vector table plus hand sequences for reset, R0/range and bulk clear.
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [1:0]        write;
   logic [1:0][4:0]   waddr;
   logic [1:0][31:0]  din;
   logic [1:0]        read;
   logic [1:0][4:0]   raddr;
   logic [1:0][31:0]  dout;
   logic [1:0][31:0]  dout_nb;
   logic              swread;
   logic [4:0]        swaddr;
   logic [31:0]       swdout;
   logic [31:0]       swdout_nb;
   logic              clr_req;
   logic              clr_busy;
   logic              busy_nb;

   logic [1:0]        z_write;
   logic [1:0][5:0]   z_waddr;
   logic [1:0][31:0]  z_din;
   logic [1:0]        z_read;
   logic [1:0][5:0]   z_raddr;
   logic [1:0][31:0]  z_dout;
   logic              z_swread;
   logic [5:0]        z_swaddr;
   logic [31:0]       z_swdout;
   logic              z_clr_req;
   logic              z_busy;

   regfile_mp #(.BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .write(write), .waddr(waddr), .din(din),
      .read(read), .raddr(raddr), .dout(dout), .swread(swread), .swaddr(swaddr),
      .swdout(swdout), .clr_req(clr_req), .clr_busy(clr_busy)
   );

   regfile_mp #(.BYPASS(0)) u_nb (
      .clk(clk), .rst(rst), .write(write), .waddr(waddr), .din(din),
      .read(read), .raddr(raddr), .dout(dout_nb), .swread(swread), .swaddr(swaddr),
      .swdout(swdout_nb), .clr_req(clr_req), .clr_busy(busy_nb)
   );

   regfile_mp #(.DEPTH(33), .ZERO_R0(1)) u_z (
      .clk(clk), .rst(rst), .write(z_write), .waddr(z_waddr), .din(z_din),
      .read(z_read), .raddr(z_raddr), .dout(z_dout), .swread(z_swread), .swaddr(z_swaddr),
      .swdout(z_swdout), .clr_req(z_clr_req), .clr_busy(z_busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;
   sb_t sb_q[$];

   logic [31:0] model [32];

   typedef struct {
      logic [1:0]  wr;
      logic [4:0]  wa0, wa1;
      logic [31:0] d0, d1;
      logic [1:0]  rd;
      logic [4:0]  ra0, ra1;
      logic        sw;
      logic [4:0]  swa;
      logic [31:0] e0, e1, enb0, enb1, esw;
   } vec_t;
   vec_t vecs[10];

   task automatic push(input string n, input logic [31:0] e);
      sb_t s;
      s.name = n;
      s.exp  = e;
      sb_q.push_back(s);
   endtask

   task automatic pop(input logic [31:0] act);
      sb_t s;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_errors++;
         $display("FAIL sb_empty actual=%h", act);
         return;
      end
      s = sb_q.pop_front();
      if (act !== s.exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", s.name, act, s.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      write = '0; waddr = '0; din = '0; read = '0; raddr = '0;
      swread = 1'b0; swaddr = '0; clr_req = 1'b0;
   endtask

   task automatic fill_index();
      for (int i = 0; i < 32; i += 2) begin
         write = 2'b11;
         waddr[0] = 5'(i);     din[0] = 32'(i);
         waddr[1] = 5'(i + 1); din[1] = 32'(i + 1);
         tick();
      end
      idle();
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 32; i += 2) begin
         read = 2'b11;
         raddr[0] = 5'(i);
         raddr[1] = 5'(i + 1);
         push($sformatf("%s_rd%0d", tag, i), model[i]);
         push($sformatf("%s_rd%0d", tag, i + 1), model[i + 1]);
         @(negedge clk);
         pop(dout[0]);
         pop(dout[1]);
         tick();
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout checks=%0d", n_checks);
      $fatal(1, "bench did not finish in time");
   end

   initial begin
      int busy_cnt;
      idle();
      z_write = '0; z_waddr = '0; z_din = '0; z_read = '0; z_raddr = '0;
      z_swread = 1'b0; z_swaddr = '0; z_clr_req = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset: preload, then check outputs are forced low while rst is high and storage clears
      write = 2'b11; waddr[0] = 5'd1; din[0] = 32'hA5A5A5A5; waddr[1] = 5'd2; din[1] = 32'hA5A5A5A5;
      tick();
      write = 2'b01; waddr[0] = 5'd3; din[0] = 32'hA5A5A5A5;
      tick();
      idle();
      read = 2'b01; raddr[0] = 5'd3;
      push("preload_r3", 32'hA5A5A5A5);
      @(negedge clk);
      pop(dout[0]);
      tick();
      rst = 1'b1;
      read = 2'b11; raddr[0] = 5'd1; raddr[1] = 5'd2; swread = 1'b1; swaddr = 5'd3;
      push("rst_dout0", 32'h0);
      push("rst_dout1", 32'h0);
      push("rst_swdout", 32'h0);
      push("rst_busy", 32'h0);
      @(negedge clk);
      pop(dout[0]);
      pop(dout[1]);
      pop(swdout);
      pop({31'b0, clr_busy});
      tick();
      rst = 1'b0;
      idle();
      for (int i = 0; i < 32; i++) model[i] = '0;
      check_all("post_rst");

      // wr, wa0, wa1, d0, d1, rd, ra0, ra1, sw, swa, e0, e1, enb0, enb1, esw
      vecs[0] = '{2'b00, 5'd0,  5'd0, 32'h0,    32'h0,    2'b11, 5'd3,  5'd4,  1'b1, 5'd3,  32'h0,    32'h0,    32'h0,    32'h0,    32'h0};
      vecs[1] = '{2'b11, 5'd5,  5'd5, 32'h11,   32'h22,   2'b01, 5'd5,  5'd6,  1'b1, 5'd5,  32'h22,   32'h0,    32'h0,    32'h0,    32'h0};
      vecs[2] = '{2'b00, 5'd0,  5'd0, 32'h0,    32'h0,    2'b01, 5'd5,  5'd5,  1'b1, 5'd5,  32'h22,   32'h0,    32'h22,   32'h0,    32'h22};
      vecs[3] = '{2'b01, 5'd7,  5'd0, 32'h1,    32'h0,    2'b11, 5'd7,  5'd5,  1'b1, 5'd7,  32'h1,    32'h22,   32'h0,    32'h22,   32'h0};
      vecs[4] = '{2'b11, 5'd9,  5'd7, 32'h33,   32'h99,   2'b11, 5'd7,  5'd9,  1'b1, 5'd7,  32'h99,   32'h33,   32'h1,    32'h0,    32'h1};
      vecs[5] = '{2'b00, 5'd0,  5'd0, 32'h0,    32'h0,    2'b11, 5'd7,  5'd9,  1'b1, 5'd9,  32'h99,   32'h33,   32'h99,   32'h33,   32'h33};
      vecs[6] = '{2'b11, 5'd31, 5'd0, 32'hDEAD, 32'hBEEF, 2'b11, 5'd31, 5'd0,  1'b1, 5'd7,  32'hDEAD, 32'hBEEF, 32'h0,    32'h0,    32'h99};
      vecs[7] = '{2'b00, 5'd0,  5'd0, 32'h0,    32'h0,    2'b11, 5'd31, 5'd0,  1'b1, 5'd31, 32'hDEAD, 32'hBEEF, 32'hDEAD, 32'hBEEF, 32'hDEAD};
      vecs[8] = '{2'b11, 5'd12, 5'd12, 32'hAAAA, 32'hBBBB, 2'b10, 5'd12, 5'd12, 1'b0, 5'd31, 32'h0,    32'hBBBB, 32'h0,    32'h0,    32'h0};
      vecs[9] = '{2'b00, 5'd0,  5'd0, 32'h0,    32'h0,    2'b11, 5'd12, 5'd12, 1'b1, 5'd12, 32'hBBBB, 32'hBBBB, 32'hBBBB, 32'hBBBB, 32'hBBBB};
      for (int v = 0; v < 10; v++) begin
         write = vecs[v].wr; waddr[0] = vecs[v].wa0; waddr[1] = vecs[v].wa1;
         din[0] = vecs[v].d0; din[1] = vecs[v].d1;
         read = vecs[v].rd; raddr[0] = vecs[v].ra0; raddr[1] = vecs[v].ra1;
         swread = vecs[v].sw; swaddr = vecs[v].swa;
         push($sformatf("v%0d_dout0", v), vecs[v].e0);
         push($sformatf("v%0d_dout1", v), vecs[v].e1);
         push($sformatf("v%0d_nb_dout0", v), vecs[v].enb0);
         push($sformatf("v%0d_nb_dout1", v), vecs[v].enb1);
         push($sformatf("v%0d_swdout", v), vecs[v].esw);
         push($sformatf("v%0d_nb_swdout", v), vecs[v].esw);
         @(negedge clk);
         pop(dout[0]);
         pop(dout[1]);
         pop(dout_nb[0]);
         pop(dout_nb[1]);
         pop(swdout);
         pop(swdout_nb);
         tick();
      end
      idle();

      // Hardwired R0 and out-of-range handling on the 33-entry instance
      z_write = 2'b01; z_waddr[0] = 6'd0; z_din[0] = 32'hFFFF;
      z_read = 2'b11; z_raddr[0] = 6'd0; z_raddr[1] = 6'd40;
      push("z_r0_bypass", 32'h0);
      push("z_oor_rd", 32'h0);
      @(negedge clk);
      pop(z_dout[0]);
      pop(z_dout[1]);
      tick();
      z_write = 2'b11; z_waddr[0] = 6'd32; z_din[0] = 32'h5; z_waddr[1] = 6'd40; z_din[1] = 32'h7;
      z_raddr[0] = 6'd32; z_raddr[1] = 6'd40;
      push("z_r32_bypass", 32'h5);
      push("z_oor_wr_bypass", 32'h0);
      @(negedge clk);
      pop(z_dout[0]);
      pop(z_dout[1]);
      tick();
      z_write = 2'b00; z_raddr[0] = 6'd0; z_raddr[1] = 6'd32; z_swread = 1'b1; z_swaddr = 6'd32;
      push("z_r0_stored", 32'h0);
      push("z_r32_stored", 32'h5);
      push("z_sw_r32", 32'h5);
      push("z_busy", 32'h0);
      @(negedge clk);
      pop(z_dout[0]);
      pop(z_dout[1]);
      pop(z_swdout);
      pop({31'b0, z_busy});
      tick();
      z_read = '0; z_swread = 1'b0;

      // Bulk clear with concurrent user writes, reads and an ignored second request
      fill_index();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 36; c++) begin
         idle();
         if (c == 5) clr_req = 1'b1;
         if (c == 10) begin
            write = 2'b01; waddr[0] = 5'd10; din[0] = 32'h77;
            read = 2'b01; raddr[0] = 5'd10;
            push("clr_bypass_r10", 32'h77);
         end
         if (c == 15) begin
            read = 2'b11; raddr[0] = 5'd31; raddr[1] = 5'd3;
            push("clr_rd_r31_pending", 32'd31);
            push("clr_rd_r3_done", 32'h0);
         end
         if (c == 25) begin
            write = 2'b10; waddr[1] = 5'd20; din[1] = 32'h55;
         end
         push($sformatf("clr_busy_c%0d", c), (c < 32) ? 32'h1 : 32'h0);
         push($sformatf("nb_busy_c%0d", c), (c < 32) ? 32'h1 : 32'h0);
         @(negedge clk);
         if (c == 10) pop(dout[0]);
         if (c == 15) begin
            pop(dout[0]);
            pop(dout[1]);
         end
         pop({31'b0, clr_busy});
         pop({31'b0, busy_nb});
         if (clr_busy) busy_cnt++;
         tick();
      end
      idle();
      push("clr_busy_total", 32'd32);
      pop(32'(busy_cnt));
      for (int i = 0; i < 32; i++) model[i] = '0;
      model[20] = 32'h55;
      check_all("after_clr");

      // Reset in the middle of a clear, then a fresh clear must start from entry 0
      fill_index();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int c = 0; c <= 12; c++) begin
         if (c == 12) rst = 1'b1;
         push($sformatf("midrst_busy_c%0d", c), (c == 12) ? 32'h0 : 32'h1);
         @(negedge clk);
         pop({31'b0, clr_busy});
         tick();
      end
      rst = 1'b0;
      push("midrst_busy_after", 32'h0);
      @(negedge clk);
      pop({31'b0, clr_busy});
      tick();
      for (int i = 0; i < 32; i++) model[i] = '0;
      check_all("after_midrst");
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int c = 0; c < 34; c++) begin
         idle();
         if (c == 0) begin
            write = 2'b01; waddr[0] = 5'd0; din[0] = 32'hAB;
         end
         if (c == 3) begin
            write = 2'b01; waddr[0] = 5'd1; din[0] = 32'hCD;
         end
         push($sformatf("reclr_busy_c%0d", c), (c < 32) ? 32'h1 : 32'h0);
         @(negedge clk);
         pop({31'b0, clr_busy});
         tick();
      end
      idle();
      model[1] = 32'hCD;
      check_all("after_reclr");

      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL sb_leftover actual=%0d expected=0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file, the next generation of the pipeline's register file.
- Storage is clocked: writes commit on the clock edge.
- Read ports are combinational, with same-cycle write-to-read bypass so the decode stage sees the value the writeback stage is writing.
- Adds a debug/software read port, an optional hardwired-zero R0, and a sequential bulk-clear engine for exception/context flush.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers. Need not be a power of 2.
- ADDR_W, $clog2(DEPTH), address width (derived).
- NR, 2, number of pipeline read ports.
- NW, 2, number of write ports.
- ZERO_R0, 0. When 1, register 0 always reads 0 and writes to it are dropped.
- BYPASS, 1. When 1, a same-cycle write is forwarded to matching reads.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  synchronous, active-high reset.
- write  in  NW  per-port write enable.
- waddr  in  NW x ADDR_W  write addresses.
- din  in  NW x DATA_W  write data.
- read  in  NR  per-port read enable.
- raddr  in  NR x ADDR_W  read addresses.
- dout  out  NR x DATA_W  read data.
- swread  in  1  debug read enable.
- swaddr  in  ADDR_W  debug read address.
- swdout  out  DATA_W  debug read data. Never bypassed.
- clr_req  in  1  start bulk clear (one-cycle pulse or level).
- clr_busy  out  1  bulk clear in progress.

Behaviour:
- Reset: one clock and reset, as already decided; rst is synchronous and active-high.
  - At a posedge with rst=1, all entries become 0, the clear FSM goes to IDLE, and the counter goes to 0.
  - While rst=1: dout, swdout = 0 and clr_busy = 0, independent of other inputs.
- Write: entry waddr[k] <= din[k] at a posedge when write[k]=1 and rst=0.
  - If several ports target the same address, the highest port index wins.
  - Address >= DEPTH: write ignored.
  - Address 0 with ZERO_R0=1: write ignored.
- Read (0-cycle, combinational):
  - read[j]=0: dout[j]=0.
  - Otherwise dout[j] = stored entry.
  - Out-of-range address: dout[j]=0.
  - ZERO_R0=1 and raddr=0: dout[j]=0.
- Bypass (BYPASS=1): if any write[k]=1 in the same cycle with waddr[k]==raddr[j] and the write is legal, dout[j] = din of the winning port.
  - With BYPASS=0, the read returns the old value.
- swdout: same rules as dout with enable swread, but always returns the stored value (no bypass).
- Clear FSM (IDLE, CLEAR):
  - IDLE and clr_req=1 -> CLEAR; counter=0; clr_busy=1 from the next cycle.
  - CLEAR: each cycle entry[counter] <= 0, then counter++. When counter==DEPTH-1, that entry is cleared and the FSM returns to IDLE, with clr_busy=0 the following cycle.
  - Total busy cycles = DEPTH.
  - clr_req while in CLEAR is ignored (no restart).
  - A user write to the current clear address in the same cycle loses: the entry becomes 0.
  - User writes to other addresses proceed. Entries already cleared may be rewritten and keep the new value.
  - Reads during CLEAR return stored contents; bypass still applies to user writes.
  - rst mid-CLEAR: full reset, FSM to IDLE.

Decomposition:
- regfile_pkg holds:
  - ZeroWord, WriteEnable, ReadEnable and RstEnable constants.
  - clr_state_t enum {CLR_IDLE, CLR_RUN}.
  - Default DATA_W and DEPTH localparams.
- Sub-module regfile_clr_fsm: state register, ADDR_W counter, clr_busy, and a (clr_we, clr_addr) output consumed by the storage write logic.
- Storage, write-priority and bypass muxing stay in regfile_mp.

Test Plan:
- Reset: preload regs 1..3 with 0xA5A5A5A5, assert rst one cycle -> all reads of 0..31 return 0; clr_busy=0.
- Multi-write priority: write[0]=write[1]=1, waddr both 5, din 0x11/0x22 -> next cycle dout[0] (raddr=5) = 0x22.
- Bypass: reg 7 = 0x1; same cycle write 7 <- 0x99 with read raddr=7 -> dout=0x99 with BYPASS=1, 0x1 with BYPASS=0; swdout=0x1 in both cases.
- ZERO_R0=1: write 0 <- 0xFFFF -> dout at raddr 0 = 0. Out-of-range raddr 40 (DEPTH=33, ADDR_W=6) -> 0.
- Bulk clear: fill all regs with their index, pulse clr_req -> clr_busy high exactly 32 cycles, then all reads return 0. A write 20 <- 0x55 issued at counter=25 survives; a write 10 <- 0x77 issued at counter=10 is lost.
- Reset mid-clear: clr_req, then rst at counter=12 -> clr_busy=0 next cycle, all entries 0, and a new clr_req starts again from counter 0.
